// File: rtl/enc_pkg.sv
// Shared types, widths and helpers for the sequential 8-to-3 encoder.
// Holds the FSM state encoding and a popcount helper used at accept time.
package enc_pkg;

   localparam int REQ_W  = 8;
   localparam int CODE_W = 3;
   localparam int CNT_W  = 4;

   typedef enum logic {
      ST_IDLE  = 1'b0,
      ST_SERVE = 1'b1
   } state_e;

   function automatic logic [CNT_W-1:0] popcnt(
      input logic [REQ_W-1:0] v
   );
      logic [CNT_W-1:0] n;
      n = '0;
      for (int i = 0; i < REQ_W; i++) begin
         n = n + {{(CNT_W-1){1'b0}}, v[i]};
      end
      return n;
   endfunction

endpackage

// File: rtl/enc8to3_seq_if.sv
// Handshake bundle for enc8to3_seq: request side (in_*, req) and code side
// (out_*, err_zero). slave = encoder view, master = producer/consumer view.
interface enc8to3_seq_if;
   import enc_pkg::*;

   logic              in_valid;
   logic              in_ready;
   logic [REQ_W-1:0]  req;
   logic              out_valid;
   logic              out_ready;
   logic [CODE_W-1:0] out_code;
   logic              out_last;
   logic [CNT_W-1:0]  out_cnt;
   logic              err_zero;

   modport slave (
      input  in_valid, req, out_ready,
      output in_ready, out_valid, out_code, out_last, out_cnt, err_zero
   );

   modport master (
      output in_valid, req, out_ready,
      input  in_ready, out_valid, out_code, out_last, out_cnt, err_zero
   );

endinterface

// File: rtl/prienc8to3.sv
// Combinational lowest-index priority encoder over the pending vector.
// Ports: pend in; code (lowest set index), any (nonzero), one_hot out.
module prienc8to3
   import enc_pkg::*;
(
   input  logic [REQ_W-1:0]  pend,
   output logic [CODE_W-1:0] code,
   output logic              any,
   output logic              one_hot
);

   always_comb begin
      code = '0;
      priority case (1'b1)
         pend[0]: code = 3'd0;
         pend[1]: code = 3'd1;
         pend[2]: code = 3'd2;
         pend[3]: code = 3'd3;
         pend[4]: code = 3'd4;
         pend[5]: code = 3'd5;
         pend[6]: code = 3'd6;
         pend[7]: code = 3'd7;
         default: code = 3'd0;
      endcase
   end

   assign any = |pend;

   // Clearing the lowest set bit leaves zero only for a single-bit vector.
   assign one_hot = any && ((pend & (pend - 8'd1)) == '0);

endmodule

// File: rtl/enc8to3_seq.sv
// Sequential 8-to-3 encoder: accepts a multi-hot vector, then emits the
// index of each set bit lowest first. Ports: clk, rst_n, bus (slave).
module enc8to3_seq
   import enc_pkg::*;
(
   input  logic         clk,
   input  logic         rst_n,
   enc8to3_seq_if.slave bus
);

   state_e            state_q, state_d;
   logic [REQ_W-1:0]  pend_q, pend_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              err_q, err_d;

   logic [CODE_W-1:0] code;
   logic              any;
   logic              one_hot;
   logic              out_valid;
   logic              in_ready;

   prienc8to3 u_pri (
      .pend    (pend_q),
      .code    (code),
      .any     (any),
      .one_hot (one_hot)
   );

   assign in_ready  = (state_q == ST_IDLE);
   assign out_valid = (state_q == ST_SERVE) && any;

   always_comb begin
      state_d = state_q;
      pend_d  = pend_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      unique case (state_q)
         ST_IDLE: begin
            if (bus.in_valid) begin
               if (bus.req != '0) begin
                  pend_d  = bus.req;
                  cnt_d   = popcnt(bus.req);
                  state_d = ST_SERVE;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         ST_SERVE: begin
            if (out_valid && bus.out_ready) begin
               pend_d[code] = 1'b0;
               if (one_hot) begin
                  state_d = ST_IDLE;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         pend_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pend_q  <= pend_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   assign bus.in_ready  = in_ready;
   assign bus.out_valid = out_valid;
   assign bus.out_code  = code;
   assign bus.out_last  = out_valid && one_hot;
   assign bus.out_cnt   = cnt_q;
   assign bus.err_zero  = err_q;

endmodule

// File: tb/tb_enc8to3_seq.sv
// Directed self-checking bench for enc8to3_seq.
// Drives and samples on the falling edge; expectations are hand-computed.
module tb_enc8to3_seq;

   logic clk;
   logic rst_n;
   int   n_chk;
   int   n_pass;

   enc8to3_seq_if bus ();

   enc8to3_seq dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag,
                      input logic [7:0] got,
                      input logic [7:0] exp);
      n_chk++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      @(negedge clk);
   endtask

   initial begin
      n_chk        = 0;
      n_pass       = 0;
      rst_n        = 1'b0;
      bus.in_valid = 1'b0;
      bus.req      = 8'h00;
      bus.out_ready = 1'b1;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // reset state
      chk("rst_in_ready", {7'd0, bus.in_ready}, 8'd1);
      chk("rst_out_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("rst_code", {5'd0, bus.out_code}, 8'd0);
      chk("rst_last", {7'd0, bus.out_last}, 8'd0);
      chk("rst_cnt", {4'd0, bus.out_cnt}, 8'd0);
      chk("rst_err", {7'd0, bus.err_zero}, 8'd0);

      // 1000_0001: codes 0, 7
      bus.in_valid = 1'b1;
      bus.req      = 8'b1000_0001;
      step();
      bus.in_valid = 1'b0;
      chk("v81_valid0", {7'd0, bus.out_valid}, 8'd1);
      chk("v81_ready0", {7'd0, bus.in_ready}, 8'd0);
      chk("v81_code0", {5'd0, bus.out_code}, 8'd0);
      chk("v81_last0", {7'd0, bus.out_last}, 8'd0);
      chk("v81_cnt", {4'd0, bus.out_cnt}, 8'd2);
      step();
      chk("v81_code1", {5'd0, bus.out_code}, 8'd7);
      chk("v81_last1", {7'd0, bus.out_last}, 8'd1);
      step();
      chk("v81_done_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("v81_done_ready", {7'd0, bus.in_ready}, 8'd1);

      // FF with stalls
      bus.in_valid = 1'b1;
      bus.req      = 8'hFF;
      step();
      bus.in_valid = 1'b0;
      for (int i = 0; i < 8; i++) begin
         chk("ff_code", {5'd0, bus.out_code}, 8'(i));
         chk("ff_last", {7'd0, bus.out_last}, {7'd0, i == 7});
         chk("ff_cnt", {4'd0, bus.out_cnt}, 8'd8);
         bus.out_ready = 1'b0;
         step();
         chk("ff_stall_valid", {7'd0, bus.out_valid}, 8'd1);
         chk("ff_stall_code", {5'd0, bus.out_code}, 8'(i));
         chk("ff_stall_last", {7'd0, bus.out_last}, {7'd0, i == 7});
         bus.out_ready = 1'b1;
         step();
      end
      chk("ff_done_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("ff_done_ready", {7'd0, bus.in_ready}, 8'd1);

      // zero vector
      bus.in_valid = 1'b1;
      bus.req      = 8'h00;
      step();
      bus.in_valid = 1'b0;
      chk("z_err", {7'd0, bus.err_zero}, 8'd1);
      chk("z_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("z_ready", {7'd0, bus.in_ready}, 8'd1);
      chk("z_cnt_hold", {4'd0, bus.out_cnt}, 8'd8);
      step();
      chk("z_err_clr", {7'd0, bus.err_zero}, 8'd0);
      chk("z_valid2", {7'd0, bus.out_valid}, 8'd0);

      // single bit
      bus.in_valid = 1'b1;
      bus.req      = 8'b0001_0000;
      step();
      bus.in_valid = 1'b0;
      chk("s_valid", {7'd0, bus.out_valid}, 8'd1);
      chk("s_code", {5'd0, bus.out_code}, 8'd4);
      chk("s_last", {7'd0, bus.out_last}, 8'd1);
      chk("s_cnt", {4'd0, bus.out_cnt}, 8'd1);
      step();
      chk("s_ready", {7'd0, bus.in_ready}, 8'd1);
      chk("s_valid_off", {7'd0, bus.out_valid}, 8'd0);

      // in_valid during SERVE is ignored
      bus.in_valid = 1'b1;
      bus.req      = 8'b0110_0000;
      step();
      bus.req      = 8'h01;
      chk("ig_code0", {5'd0, bus.out_code}, 8'd5);
      chk("ig_last0", {7'd0, bus.out_last}, 8'd0);
      step();
      chk("ig_code1", {5'd0, bus.out_code}, 8'd6);
      chk("ig_last1", {7'd0, bus.out_last}, 8'd1);
      chk("ig_cnt", {4'd0, bus.out_cnt}, 8'd2);
      step();
      bus.in_valid = 1'b0;
      chk("ig_done_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("ig_done_ready", {7'd0, bus.in_ready}, 8'd1);

      // async reset mid-burst
      bus.in_valid = 1'b1;
      bus.req      = 8'b1110_0000;
      step();
      bus.in_valid = 1'b0;
      chk("ar_code0", {5'd0, bus.out_code}, 8'd5);
      step();
      chk("ar_code1", {5'd0, bus.out_code}, 8'd6);
      #2 rst_n = 1'b0;
      #1;
      chk("ar_valid", {7'd0, bus.out_valid}, 8'd0);
      chk("ar_ready", {7'd0, bus.in_ready}, 8'd1);
      chk("ar_code", {5'd0, bus.out_code}, 8'd0);
      chk("ar_last", {7'd0, bus.out_last}, 8'd0);
      chk("ar_cnt", {4'd0, bus.out_cnt}, 8'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("ar_idle_valid", {7'd0, bus.out_valid}, 8'd0);
      bus.in_valid = 1'b1;
      bus.req      = 8'b0000_0110;
      step();
      bus.in_valid = 1'b0;
      chk("pr_code0", {5'd0, bus.out_code}, 8'd1);
      chk("pr_last0", {7'd0, bus.out_last}, 8'd0);
      chk("pr_cnt", {4'd0, bus.out_cnt}, 8'd2);
      step();
      chk("pr_code1", {5'd0, bus.out_code}, 8'd2);
      chk("pr_last1", {7'd0, bus.out_last}, 8'd1);
      step();
      chk("pr_done_ready", {7'd0, bus.in_ready}, 8'd1);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
